// File: rtl/common_dffram_2a1wb2r_arb.sv
// ============================================================================
// common_dffram_2a1wb2r_arb
//
// Port-A sequencer/arbiter for the 2-address, 1-write-with-bit-enable, 2-read
// DFF RAM. Two requesters (m0, m1) share RAM port A under round-robin
// arbitration. Read data comes back registered, one cycle after acceptance,
// and holds the pre-write (read-first) contents. After reset (optionally) and
// on a clr pulse the block sweeps every entry with INIT_VALUE.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   clr                 single-cycle pulse, starts a sweep when IDLE
//   busy                sweep pending or in progress
//   mX_valid/mX_ready   request handshake (ready is combinational grant)
//   mX_addr/wbe/wdata   request address, per-bit write enable, write data
//   mX_rvalid/mX_rdata  one-cycle read response, data held until next accept
//   ram_addra/ena/wea/dina  drive RAM port A
//   ram_douta           RAM port A read data (combinational, read-first)
// ============================================================================
module common_dffram_2a1wb2r_arb #(
    parameter int unsigned                  RAM_DATA_WIDTH = 8,
    parameter int unsigned                  RAM_ADDR_WIDTH = 4,
    parameter logic [RAM_DATA_WIDTH-1:0]    INIT_VALUE     = '0,
    parameter bit                           INIT_ON_RESET  = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    output logic                        busy,

    input  logic                        m0_valid,
    output logic                        m0_ready,
    input  logic [RAM_ADDR_WIDTH-1:0]   m0_addr,
    input  logic [RAM_DATA_WIDTH-1:0]   m0_wbe,
    input  logic [RAM_DATA_WIDTH-1:0]   m0_wdata,
    output logic                        m0_rvalid,
    output logic [RAM_DATA_WIDTH-1:0]   m0_rdata,

    input  logic                        m1_valid,
    output logic                        m1_ready,
    input  logic [RAM_ADDR_WIDTH-1:0]   m1_addr,
    input  logic [RAM_DATA_WIDTH-1:0]   m1_wbe,
    input  logic [RAM_DATA_WIDTH-1:0]   m1_wdata,
    output logic                        m1_rvalid,
    output logic [RAM_DATA_WIDTH-1:0]   m1_rdata,

    output logic [RAM_ADDR_WIDTH-1:0]   ram_addra,
    output logic                        ram_ena,
    output logic [RAM_DATA_WIDTH-1:0]   ram_wea,
    output logic [RAM_DATA_WIDTH-1:0]   ram_dina,
    input  logic [RAM_DATA_WIDTH-1:0]   ram_douta
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_INIT = 1'b1
    } state_t;

    localparam state_t                      RESET_STATE = INIT_ON_RESET ? S_INIT : S_IDLE;
    localparam logic [RAM_ADDR_WIDTH-1:0]   ADDR_ONE    = {{(RAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                         state;
    state_t                         next_state;
    logic [RAM_ADDR_WIDTH-1:0]      sweep_cnt;
    // 1 = m1 was granted most recently, so m0 wins the next conflict.
    logic                           last_grant;
    logic                           grant0;
    logic                           grant1;

    // ------------------------------------------------------------------
    // Next state, arbitration and RAM port-A drive
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        ram_ena    = 1'b0;
        ram_addra  = '0;
        ram_wea    = '0;
        ram_dina   = '0;

        unique case (state)
            S_INIT: begin
                ram_ena   = 1'b1;
                ram_wea   = '1;
                ram_addra = sweep_cnt;
                ram_dina  = INIT_VALUE;
                if (sweep_cnt == '1) begin
                    next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr) begin
                    next_state = S_INIT;
                end else if (m0_valid && m1_valid) begin
                    grant0 = last_grant;
                    grant1 = ~last_grant;
                end else begin
                    grant0 = m0_valid;
                    grant1 = m1_valid;
                end

                if (grant0) begin
                    ram_ena   = 1'b1;
                    ram_addra = m0_addr;
                    ram_wea   = m0_wbe;
                    ram_dina  = m0_wdata;
                end else if (grant1) begin
                    ram_ena   = 1'b1;
                    ram_addra = m1_addr;
                    ram_wea   = m1_wbe;
                    ram_dina  = m1_wdata;
                end
            end
            default: next_state = RESET_STATE;
        endcase
    end

    assign m0_ready = grant0;
    assign m1_ready = grant1;
    assign busy     = (state == S_INIT) || ((state == S_IDLE) && clr);

    // ------------------------------------------------------------------
    // State, sweep counter, round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RESET_STATE;
            sweep_cnt  <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            // Counter wraps to zero naturally at the last address.
            if (state == S_INIT) begin
                sweep_cnt <= sweep_cnt + ADDR_ONE;
            end else begin
                sweep_cnt <= '0;
            end
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read responses: capture read-first data at the accepting edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= grant0;
            m1_rvalid <= grant1;
            if (grant0) begin
                m0_rdata <= ram_douta;
            end
            if (grant1) begin
                m1_rdata <= ram_douta;
            end
        end
    end

endmodule

// File: doc/common_dffram_2a1wb2r_arb.md
# common_dffram_2a1wb2r_arb

Sequencing and arbitration controller for port A of the 2-address, 1-write-with-bit-enable, 2-read DFF RAM. It shares the single read/write port A between two requesters under round-robin arbitration and returns registered read data. After reset, and on demand, it sweeps every entry with a fixed initialisation value. Port B of the RAM stays a free read port and is not touched by this block.

## Interface
- RAM_DATA_WIDTH, 8: data width of the RAM word.
- RAM_ADDR_WIDTH, 4: address width; depth = 2^RAM_ADDR_WIDTH.
- INIT_VALUE, 0 (RAM_DATA_WIDTH bits): word written to every entry by a sweep.
- INIT_ON_RESET, 1: 1 = sweep automatically after reset release; 0 = come out of reset in IDLE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- clr  in  1  single-cycle pulse; starts a sweep.
- busy  out  1  high while a sweep is pending or in progress.
- m0_valid / m1_valid  in  1  request valid.
- m0_ready / m1_ready  out  1  request accepted this cycle.
- m0_addr / m1_addr  in  RAM_ADDR_WIDTH  request address.
- m0_wbe / m1_wbe  in  RAM_DATA_WIDTH  per-bit write enable; all-zero means a pure read.
- m0_wdata / m1_wdata  in  RAM_DATA_WIDTH  write data.
- m0_rvalid / m1_rvalid  out  1  read response valid, one cycle.
- m0_rdata / m1_rdata  out  RAM_DATA_WIDTH  read response data, old contents.
- ram_addra  out  RAM_ADDR_WIDTH  to RAM addra.
- ram_ena  out  1  to RAM ena.
- ram_wea  out  RAM_DATA_WIDTH  to RAM wea.
- ram_dina  out  RAM_DATA_WIDTH  to RAM dina.
- ram_douta  in  RAM_DATA_WIDTH  from RAM douta (combinational, read-first).

## Operation
- FSM has two states.
  - IDLE: serve requests.
  - INIT: sweep.
- Reset state is INIT if INIT_ON_RESET=1, otherwise IDLE.
- INIT state:
  - Sweep counter runs 0 to 2^RAM_ADDR_WIDTH-1, one entry per cycle.
  - Each cycle drives ram_ena=1, ram_wea=all-ones, ram_addra=counter, ram_dina=INIT_VALUE.
  - At the last address, the next state is IDLE and the counter returns to 0.
  - m0_ready and m1_ready are 0 throughout.
  - clr is ignored, with no restart.
- IDLE state:
  - If clr=1: both readies are 0 that cycle, no RAM access, and the next state is INIT.
  - Otherwise, a grant goes to a valid requester.
  - Both valid: grant goes to the requester not granted most recently.
  - Round-robin pointer last_grant resets to 1, so m0 wins the first conflict.
  - A granted requester sees mX_ready=1 combinationally, with no dependency on mX_ready in valid.
  - RAM is driven in the same cycle: ram_ena=1, ram_addra=mX_addr, ram_wea=mX_wbe, ram_dina=mX_wdata.
- Read response: ram_douta is captured into mX_rdata at the accepting edge.
  - mX_rvalid=1 for exactly the next cycle, for reads and writes alike.
  - The data is the pre-write contents, per read-first behaviour.
  - mX_rdata holds its value until the next accept for that requester.
- No accept: ram_ena=0, ram_wea=0, ram_addra=0, ram_dina=0.
- busy = (state==INIT) or (state==IDLE and clr).

## Timing
- Reset values: m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, sweep counter=0, last_grant=1.
- Reset values (continued): busy=INIT_ON_RESET, both readies=0 if INIT_ON_RESET=1.
- Reset assertion mid-sweep or mid-transaction:
  - Registers clear immediately.
  - A pending rvalid is dropped.
  - RAM contents are not restored by this block; the RAM's own reset handles that.
- Sweep length is exactly 2^RAM_ADDR_WIDTH cycles.
  - First request acceptance is possible in cycle 2^RAM_ADDR_WIDTH after reset release.
  - It is possible in cycle 2^RAM_ADDR_WIDTH+1 after a clr pulse.
- Request-to-response latency is 1 cycle.
- Throughput is one access per cycle across both requesters.
- Back-to-back accesses to the same address: the second read returns the first write's result.
- A requester holding valid while losing arbitration must keep addr/wbe/wdata stable until ready.
- Sweep counter wraps from 2^RAM_ADDR_WIDTH-1 to 0 with no overflow bit.

## Test plan
- INIT_ON_RESET=1, INIT_VALUE=8'hA5, ADDR_WIDTH=4: release reset.
  - busy is high 16 cycles.
  - ram_addra steps 0..15 with ram_wea=8'hFF.
  - A subsequent m0 read of addr 7 returns 8'hA5 with rvalid one cycle later.
- m0 writes addr 3 data 8'h3C with wbe 8'hFF, then reads addr 3 the next cycle.
  - The first response is 8'hA5 (old data).
  - The second response is 8'h3C.
- Bit enable: write 8'hFF with wbe 8'h0F to addr 2 (holding 8'hA5), then read.
  - Read returns 8'hAF.
- Both valid continuously for 6 cycles.
  - Grants alternate m0,m1,m0,m1,m0,m1.
  - Exactly one rvalid per cycle from cycle 2.
- clr pulse in IDLE while m1_valid=1.
  - m1_ready=0 that cycle; the sweep rewrites all 16 entries.
  - m1 is accepted in the cycle after the sweep ends.
  - A second clr pulse mid-sweep has no effect.
- Drive reset low at sweep address 9.
  - Outputs return to reset values asynchronously.
  - After release the sweep restarts at address 0.
